// File: rtl/dbi_pkg.sv
// Shared constants for the 128-bit link DBI encoder/decoder pair and its monitors.
package dbi_pkg;

    localparam int unsigned DBI_BW      = 128;
    localparam int unsigned DBI_CNT_W   = $clog2(DBI_BW) + 1;
    localparam int unsigned DBI_STATS_W = 32;

endpackage

// File: rtl/dbi_encode_128b_popcount_tree.sv
// popcount_tree: combinational population count built as a balanced recursive adder tree.
module popcount_tree #(
    parameter int unsigned W  = 128,
    parameter int unsigned OW = $clog2(W) + 1
) (
    input  logic [W-1:0]  bits_i,
    output logic [OW-1:0] count_o
);

    generate
        if (W == 1) begin : g_leaf
            always_comb begin
                count_o = OW'(bits_i);
            end
        end else begin : g_split
            localparam int unsigned WL  = W / 2;
            localparam int unsigned WH  = W - WL;
            localparam int unsigned OWL = $clog2(WL) + 1;
            localparam int unsigned OWH = $clog2(WH) + 1;

            logic [OWL-1:0] cnt_lo;
            logic [OWH-1:0] cnt_hi;

            popcount_tree #(.W(WL), .OW(OWL)) u_lo (
                .bits_i  (bits_i[WL-1:0]),
                .count_o (cnt_lo)
            );

            popcount_tree #(.W(WH), .OW(OWH)) u_hi (
                .bits_i  (bits_i[W-1:WL]),
                .count_o (cnt_hi)
            );

            always_comb begin
                count_o = OW'(cnt_lo) + OW'(cnt_hi);
            end
        end
    endgenerate

endmodule

// File: rtl/dbi_encode_128b.sv
// Two-stage AC-DBI transmit encoder; optional inversion counter under `DBI_ENC_STATS_EN`.
module dbi_encode_128b
    import dbi_pkg::*;
#(
    parameter int unsigned bw = DBI_BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dbi_en,
    input  logic          valid_in,
    input  logic [bw-1:0] data_in,
    output logic          valid_out,
    output logic [bw:0]   data_out
`ifdef DBI_ENC_STATS_EN
    ,
    output logic [DBI_STATS_W-1:0] inv_count
`endif
);

    localparam int unsigned CW = $clog2(bw) + 1;

    logic [bw-1:0] prev_raw_q, prev_raw_d;
    logic          inv_prev_q, inv_prev_d;

    logic          s1_valid_q, s1_valid_d;
    logic [bw-1:0] s1_data_q,  s1_data_d;
    logic          s1_en_q,    s1_en_d;
    logic [CW-1:0] s1_t_q,     s1_t_d;

    logic          valid_out_q, valid_out_d;
    logic [bw:0]   data_out_q,  data_out_d;

    logic [bw-1:0] raw_diff;
    logic [CW-1:0] raw_toggles;
    logic [CW-1:0] tog;
    logic          inv;

    // Stage 1 counts toggles against the last raw word, independent of its encoding
    always_comb begin
        raw_diff = data_in ^ prev_raw_q;
    end

    popcount_tree #(.W(bw), .OW(CW)) u_popcount (
        .bits_i  (raw_diff),
        .count_o (raw_toggles)
    );

    always_comb begin
        s1_valid_d = valid_in;
        s1_data_d  = s1_data_q;
        s1_en_d    = s1_en_q;
        s1_t_d     = s1_t_q;
        prev_raw_d = prev_raw_q;
        if (valid_in) begin
            s1_data_d  = data_in;
            s1_en_d    = dbi_en;
            s1_t_d     = raw_toggles;
            prev_raw_d = data_in;
        end
    end

    // If the previous word went out inverted, every non-toggling raw bit toggles on the bus
    always_comb begin
        tog = inv_prev_q ? (CW'(bw) - s1_t_q) : s1_t_q;
        inv = s1_en_q & (tog > CW'(bw / 2));
    end

    always_comb begin
        valid_out_d = s1_valid_q;
        data_out_d  = data_out_q;
        inv_prev_d  = inv_prev_q;
        if (s1_valid_q) begin
            data_out_d = {inv, (inv ? ~s1_data_q : s1_data_q)};
            inv_prev_d = inv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_raw_q  <= '0;
            inv_prev_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_en_q     <= 1'b0;
            s1_t_q      <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            prev_raw_q  <= prev_raw_d;
            inv_prev_q  <= inv_prev_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_en_q     <= s1_en_d;
            s1_t_q      <= s1_t_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    always_comb begin
        valid_out = valid_out_q;
        data_out  = data_out_q;
    end

`ifdef DBI_ENC_STATS_EN
    logic [DBI_STATS_W-1:0] inv_count_q, inv_count_d;

    always_comb begin
        inv_count_d = inv_count_q;
        if (s1_valid_q && inv && (inv_count_q != '1)) begin
            inv_count_d = inv_count_q + DBI_STATS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_count_q <= '0;
        end else begin
            inv_count_q <= inv_count_d;
        end
    end

    always_comb begin
        inv_count = inv_count_q;
    end
`endif

endmodule
